// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the fetch PC, absorbs the one-cycle synchronous memory read
// latency and buffers returned words in a small FIFO that decode drains via valid/ready.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_en,
    output logic [31:0]                  mem_addr,
    input  logic [31:0]                  mem_inst,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_pc,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic [$clog2(BUF_DEPTH):0]   buf_count
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(BUF_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);

    logic [31:0]   fetch_pc_reg;
    logic [31:0]   tag_pc_reg;
    logic          inflight_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   inst_buf_reg [BUF_DEPTH];
    logic [31:0]   pc_buf_reg   [BUF_DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy_next;

    // Redirect squashes both the pop and the returning word, so neither may move the FIFO.
    assign pop  = inst_valid & inst_ready & ~redirect;
    assign push = inflight_reg & ~redirect;

    // Slots already committed after this edge; a new read is issued only if its word has a home.
    assign occupancy_next = {1'b0, count_reg}
                          + {{CW{1'b0}}, inflight_reg}
                          - {{CW{1'b0}}, pop};
    assign issue = fetch_en & ~redirect & (occupancy_next < DEPTH_EXT);

    assign mem_addr   = fetch_pc_reg;
    assign inst_valid = (count_reg != '0);
    assign buf_count  = count_reg;
    assign inst       = inst_buf_reg[rd_ptr_reg];
    assign inst_pc    = pc_buf_reg[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            tag_pc_reg   <= '0;
            inflight_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else if (redirect) begin
            fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
            inflight_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (issue) begin
                tag_pc_reg   <= fetch_pc_reg;
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            inflight_reg <= issue;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Storage is cleared on reset so the head outputs read as zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                inst_buf_reg[i] <= '0;
                pc_buf_reg[i]   <= '0;
            end
        end else if (push) begin
            inst_buf_reg[wr_ptr_reg] <= mem_inst;
            pc_buf_reg[wr_ptr_reg]   <= tag_pc_reg;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_reg == DEPTH_CNT));

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Sequences the byte-addressed, synchronous-read instruction memory: owns the fetch PC and drives the memory address.
- Absorbs the memory's one-cycle read latency and buffers returned words in a small FIFO.
- Presents words to decode with a valid/ready handshake.
- Accepts PC redirects (branch/jump) from execute and flushes stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, instruction FIFO entries (power of 2, >= 2).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- fetch_en  input  1  when 0, no new memory reads are issued; in-flight and buffered words still drain.
- mem_addr  output  32  address to instruction memory; sampled by memory at posedge.
- mem_inst  input  32  memory read data, valid the cycle after mem_addr was sampled.
- inst  output  32  FIFO head instruction.
- inst_pc  output  32  byte address of inst.
- inst_valid  output  1  FIFO non-empty.
- inst_ready  input  1  decode accepts head; pop = inst_valid & inst_ready.
- redirect  input  1  load new PC and flush, single-cycle strobe.
- redirect_pc  input  32  target PC; bits [1:0] forced to 0 internally.
- buf_count  output  $clog2(BUF_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, FIFO empty, inflight=0, inst_valid=0, buf_count=0, inst=0, inst_pc=0; mem_addr=RESET_PC.
- mem_addr = fetch_pc combinationally at all times. The memory reads every cycle. A read counts only when issue=1 in that cycle; otherwise its data is ignored.
- issue = fetch_en & ~redirect & (buf_count + inflight - pop < BUF_DEPTH).
- On issue at edge k: record inflight=1 with tag_pc=fetch_pc, then fetch_pc += 4 (32-bit, wraps 0xFFFF_FFFC -> 0).
- Cycle after issue: mem_inst is pushed with inst_pc=tag_pc at the next edge; inflight clears unless a new issue occurs the same edge.
- Latency: with an empty FIFO, inst_valid rises 2 edges after fetch_pc is presented with issue=1, i.e. the first word is visible in cycle 2 after reset release.
- Throughput: 1 instruction/cycle when inst_ready is held high and fetch_en=1.
- FIFO:
  - Simultaneous push and pop are allowed at any occupancy, including full.
  - Push never occurs into a full FIFO; the issue rule guarantees this. A push to a full FIFO is an assertion failure.
  - Head outputs are stable while inst_valid=1 & inst_ready=0.
- Redirect has priority over everything:
  - At the edge: fetch_pc={redirect_pc[31:2],2'b00}, FIFO cleared, inflight cleared (the returning word is discarded), no issue that cycle. Any pop in that cycle is ignored (redirect wins).
  - inst_valid=0 in the cycle after redirect.
  - The first word from the target appears 2 edges after the redirect edge.
  - Back-to-back redirects: the last one wins, and each restarts the 2-edge latency.
- fetch_en low mid-stream: the current in-flight word still lands and buffered words drain; fetch_pc holds.
- Memory wrap: fetch_pc is full 32 bits; the memory decodes only [9:0]. The unit performs no range checks.
- Reset asserted mid-operation: immediate return to reset state; in-flight data is dropped.

Test Plan:
- Reset/basic stream: memory word 0=0x8C610000, word 4=0x8C430001. Release rst with fetch_en=1, inst_ready=1.
  -> cycle 2: inst=0x8C610000, inst_pc=0. Cycle 3: inst=0x8C430001, inst_pc=4. Cycle 4: inst_pc=8, inst=0.
- Backpressure: inst_ready=0 from cycle 2 for 5 cycles.
  -> buf_count saturates at 2 and inst holds 0x8C610000. mem_addr stops at 8 (no issue).
  -> On inst_ready=1, inst_pc sequence 0,4,8,12 with no gaps or duplicates.
- Redirect mid-stream: redirect=1, redirect_pc=0x102 while FIFO holds 2 entries and a read is in flight.
  -> next cycle inst_valid=0, buf_count=0. Then inst_pc=0x100 two edges later, then 0x104.
- Redirect with pop same cycle, and back-to-back redirects to 0x40 then 0x80.
  -> the pop is not honoured; only 0x80 is fetched, and no 0x40 word ever reaches inst_valid.
- fetch_en gating: drop fetch_en for 3 cycles with inst_ready=1.
  -> at most one more word (the in-flight one) is delivered. mem_addr holds. Resume yields consecutive PCs.
- Async reset mid-stream: assert rst between edges.
  -> inst_valid=0 and mem_addr=RESET_PC immediately, without waiting for a clock edge. After release, the stream restarts at inst_pc=0.
